// File: rtl/control_ajuste_pkg.sv
// Shared definitions for the time-set controller: mode encoding and small helpers.
package control_ajuste_pkg;

    typedef enum logic [1:0] {
        MODO_RUN      = 2'b00,
        MODO_SET_HORA = 2'b01,
        MODO_SET_MIN  = 2'b10,
        MODO_INVALIDO = 2'b11
    } modo_t;

    localparam logic [3:0] ANODO_TODOS = 4'b1111;

    function automatic logic es_ajuste(input modo_t m);
        return (m == MODO_SET_HORA) || (m == MODO_SET_MIN);
    endfunction

endpackage

// File: rtl/antirrebote.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and press pulse.
module antirrebote
    import control_ajuste_pkg::*;
#(
    parameter int DEB_CUENTA = 1_000_000,
    parameter int DEB_BITS   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic nivel,
    output logic pulso
);

    logic                sinc1_r;
    logic                sinc2_r;
    logic                nivel_r;
    logic                pulso_r;
    logic [DEB_BITS-1:0] cnt_r;
    logic                difiere_s;
    logic                vence_s;

    assign difiere_s = (sinc2_r != nivel_r);
    assign vence_s   = difiere_s && (cnt_r == DEB_BITS'(DEB_CUENTA - 1));

    // Synchronizer, stability counter, accepted level and its rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc1_r <= 1'b0;
            sinc2_r <= 1'b0;
            nivel_r <= 1'b0;
            pulso_r <= 1'b0;
            cnt_r   <= {DEB_BITS{1'b0}};
        end else begin
            sinc1_r <= btn;
            sinc2_r <= sinc1_r;
            pulso_r <= vence_s && !nivel_r;
            if (vence_s) begin
                nivel_r <= ~nivel_r;
                cnt_r   <= {DEB_BITS{1'b0}};
            end else if (difiere_s) begin
                cnt_r   <= cnt_r + DEB_BITS'(1);
            end else begin
                cnt_r   <= {DEB_BITS{1'b0}};
            end
        end
    end

    assign nivel = nivel_r;
    assign pulso = pulso_r;

endmodule

// File: rtl/control_ajuste.sv
// Time-set controller: mode FSM, tick gating, increment pulses with auto-repeat,
// and blink enables for the display.
module control_ajuste
    import control_ajuste_pkg::*;
#(
    parameter int DEB_CUENTA   = 1_000_000,
    parameter int DEB_BITS     = 20,
    parameter int BLINK_CUENTA = 25_000_000,
    parameter int BLINK_BITS   = 25,
    parameter int REP_INICIO   = 50_000_000,
    parameter int REP_PERIODO  = 20_000_000,
    parameter int REP_BITS     = 26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MODO,
    input  logic       BTN_INC,
    input  logic       TICK_1HZ,
    output logic       CE_SEG,
    output logic       INC_MIN,
    output logic       INC_HORA,
    output logic       CLR_SEG,
    output logic [3:0] ANODO_EN,
    output logic       HORAS_EN,
    output logic [1:0] MODO
);

    logic                  modo_nivel_unused_s;
    logic                  modo_press_s;
    logic                  inc_nivel_s;
    logic                  inc_press_s;

    modo_t                 estado_r;
    modo_t                 estado_sig_s;

    logic [BLINK_BITS-1:0] blink_cnt_r;
    logic [BLINK_BITS-1:0] blink_cnt_sig_s;
    logic                  fase_r;
    logic                  fase_sig_s;
    logic                  entra_ajuste_s;

    logic [REP_BITS-1:0]   rep_cnt_r;
    logic                  rep_siguiente_r;
    logic [REP_BITS-1:0]   rep_limite_s;
    logic                  rep_activo_s;
    logic                  rep_dispara_s;
    logic                  inc_evento_s;

    logic                  ce_seg_r;
    logic                  inc_min_r;
    logic                  inc_hora_r;
    logic                  clr_seg_r;
    logic [3:0]            anodo_r;
    logic                  horas_r;
    logic [3:0]            anodo_sig_s;
    logic                  horas_sig_s;

    antirrebote #(.DEB_CUENTA(DEB_CUENTA), .DEB_BITS(DEB_BITS)) u_deb_modo (
        .clk   (CLK),
        .rst_n (RST),
        .btn   (BTN_MODO),
        .nivel (modo_nivel_unused_s),
        .pulso (modo_press_s)
    );

    antirrebote #(.DEB_CUENTA(DEB_CUENTA), .DEB_BITS(DEB_BITS)) u_deb_inc (
        .clk   (CLK),
        .rst_n (RST),
        .btn   (BTN_INC),
        .nivel (inc_nivel_s),
        .pulso (inc_press_s)
    );

    // Mode sequence; the unused encoding falls back to RUN.
    always_comb begin
        estado_sig_s = estado_r;
        case (estado_r)
            MODO_RUN:      if (modo_press_s) estado_sig_s = MODO_SET_HORA; else estado_sig_s = MODO_RUN;
            MODO_SET_HORA: if (modo_press_s) estado_sig_s = MODO_SET_MIN;  else estado_sig_s = MODO_SET_HORA;
            MODO_SET_MIN:  if (modo_press_s) estado_sig_s = MODO_RUN;      else estado_sig_s = MODO_SET_MIN;
            default:       estado_sig_s = MODO_RUN;
        endcase
    end

    // Mode state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            estado_r <= MODO_RUN;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Blink phase: restarts visible on every entry into a SET state.
    assign entra_ajuste_s = es_ajuste(estado_sig_s) && (estado_sig_s != estado_r);

    // Next blink counter and phase.
    always_comb begin
        blink_cnt_sig_s = blink_cnt_r + BLINK_BITS'(1);
        fase_sig_s      = fase_r;
        if (entra_ajuste_s) begin
            blink_cnt_sig_s = {BLINK_BITS{1'b0}};
            fase_sig_s      = 1'b1;
        end else if (blink_cnt_r == BLINK_BITS'(BLINK_CUENTA - 1)) begin
            blink_cnt_sig_s = {BLINK_BITS{1'b0}};
            fase_sig_s      = ~fase_r;
        end else begin
            blink_cnt_sig_s = blink_cnt_r + BLINK_BITS'(1);
            fase_sig_s      = fase_r;
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            blink_cnt_r <= {BLINK_BITS{1'b0}};
            fase_r      <= 1'b1;
        end else begin
            blink_cnt_r <= blink_cnt_sig_s;
            fase_r      <= fase_sig_s;
        end
    end

    // Auto-repeat runs only while INC is held and the mode is stable in a SET state.
    assign rep_limite_s  = rep_siguiente_r ? REP_BITS'(REP_PERIODO) : REP_BITS'(REP_INICIO);
    assign rep_activo_s  = inc_nivel_s && es_ajuste(estado_r) && (estado_sig_s == estado_r);
    assign rep_dispara_s = rep_activo_s && (rep_cnt_r == rep_limite_s);
    assign inc_evento_s  = !modo_press_s && (inc_press_s || rep_dispara_s);

    // Repeat counter; reloads to 1 after each repeat so the period counts from the pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rep_cnt_r       <= {REP_BITS{1'b0}};
            rep_siguiente_r <= 1'b0;
        end else if (!rep_activo_s) begin
            rep_cnt_r       <= {REP_BITS{1'b0}};
            rep_siguiente_r <= 1'b0;
        end else if (rep_dispara_s) begin
            rep_cnt_r       <= REP_BITS'(1);
            rep_siguiente_r <= 1'b1;
        end else begin
            rep_cnt_r       <= rep_cnt_r + REP_BITS'(1);
            rep_siguiente_r <= rep_siguiente_r;
        end
    end

    // Display enables follow the next mode so they change together with MODO.
    always_comb begin
        anodo_sig_s = ANODO_TODOS;
        horas_sig_s = 1'b1;
        case (estado_sig_s)
            MODO_RUN: begin
                anodo_sig_s = ANODO_TODOS;
                horas_sig_s = 1'b1;
            end
            MODO_SET_HORA: begin
                anodo_sig_s = ANODO_TODOS;
                horas_sig_s = fase_sig_s;
            end
            MODO_SET_MIN: begin
                anodo_sig_s = {fase_sig_s, fase_sig_s, 2'b11};
                horas_sig_s = 1'b1;
            end
            default: begin
                anodo_sig_s = ANODO_TODOS;
                horas_sig_s = 1'b1;
            end
        endcase
    end

    // Output registers; pulse decisions use the pre-transition mode.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ce_seg_r   <= 1'b0;
            inc_min_r  <= 1'b0;
            inc_hora_r <= 1'b0;
            clr_seg_r  <= 1'b0;
            anodo_r    <= ANODO_TODOS;
            horas_r    <= 1'b1;
        end else begin
            ce_seg_r   <= TICK_1HZ && (estado_r == MODO_RUN);
            inc_hora_r <= inc_evento_s && (estado_r == MODO_SET_HORA);
            inc_min_r  <= inc_evento_s && (estado_r == MODO_SET_MIN);
            clr_seg_r  <= modo_press_s && (estado_r == MODO_SET_MIN);
            anodo_r    <= anodo_sig_s;
            horas_r    <= horas_sig_s;
        end
    end

    assign CE_SEG   = ce_seg_r;
    assign INC_MIN  = inc_min_r;
    assign INC_HORA = inc_hora_r;
    assign CLR_SEG  = clr_seg_r;
    assign ANODO_EN = anodo_r;
    assign HORAS_EN = horas_r;
    assign MODO     = estado_r;

endmodule

// File: tb/tb_control_ajuste.sv
// Scoreboard bench for control_ajuste: stimulus pushes expected pulse events and
// mode transitions derived from the button/tick timing rules; a monitor checks them.
module tb_control_ajuste;

    localparam int DEB   = 4;
    localparam int BLINK = 8;
    localparam int RINI  = 20;
    localparam int RPER  = 6;
    localparam int LAT   = 2 + DEB + 1;

    localparam int K_CE   = 0;
    localparam int K_MIN  = 1;
    localparam int K_HORA = 2;
    localparam int K_CLR  = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BTN_MODO = 1'b0;
    logic       BTN_INC = 1'b0;
    logic       TICK_1HZ = 1'b0;
    logic       CE_SEG;
    logic       INC_MIN;
    logic       INC_HORA;
    logic       CLR_SEG;
    logic [3:0] ANODO_EN;
    logic       HORAS_EN;
    logic [1:0] MODO;

    control_ajuste #(
        .DEB_CUENTA(DEB), .DEB_BITS(4), .BLINK_CUENTA(BLINK), .BLINK_BITS(4),
        .REP_INICIO(RINI), .REP_PERIODO(RPER), .REP_BITS(6)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN_MODO(BTN_MODO), .BTN_INC(BTN_INC), .TICK_1HZ(TICK_1HZ),
        .CE_SEG(CE_SEG), .INC_MIN(INC_MIN), .INC_HORA(INC_HORA), .CLR_SEG(CLR_SEG),
        .ANODO_EN(ANODO_EN), .HORAS_EN(HORAS_EN), .MODO(MODO)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed { int c; int k; } ev_t;
    ev_t esperados[$];

    int vectors = 0;
    int miscompares = 0;
    bit fin = 1'b0;

    // Mode timeline: m_cur takes effect from cycle m_cyc; e_* are SET entry cycles.
    int m_prev = 0, m_cur = 0, m_cyc = 0, e_prev = 0, e_cur = 0;

    function automatic int mode_at(input int c);
        return (c >= m_cyc) ? m_cur : m_prev;
    endfunction

    function automatic int entry_at(input int c);
        return (c >= m_cyc) ? e_cur : e_prev;
    endfunction

    function automatic logic [6:0] expected_disp(input int c);
        int m;
        bit ph;
        m  = mode_at(c);
        ph = (((c - entry_at(c)) / BLINK) % 2) == 0;
        if (m == 1) return {2'b01, 4'b1111, ph};
        else if (m == 2) return {2'b10, ph, ph, 2'b11, 1'b1};
        else return {2'b00, 4'b1111, 1'b1};
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_CE:    return "CE_SEG";
            K_MIN:   return "INC_MIN";
            K_HORA:  return "INC_HORA";
            default: return "CLR_SEG";
        endcase
    endfunction

    task automatic push(input int c, input int k);
        ev_t e;
        e.c = c;
        e.k = k;
        esperados.push_back(e);
    endtask

    task automatic check_pulse(input logic v, input int k);
        int idx;
        idx = -1;
        for (int i = 0; i < esperados.size(); i++)
            if (esperados[i].c == cyc && esperados[i].k == k) idx = i;
        if (v) begin
            vectors++;
            if (idx >= 0) esperados.delete(idx);
            else begin
                miscompares++;
                $display("FAIL %s cyc=%0d got 1 expected 0", kname(k), cyc);
            end
        end
    endtask

    logic [6:0]  exp_m;
    logic [10:0] rst_act;

    // Monitor: sampled 1 time unit after each falling clock edge or reset assertion.
    always begin
        @(negedge CLK or negedge RST);
        #1;
        if (!RST) begin
            vectors++;
            rst_act = {CE_SEG, INC_MIN, INC_HORA, CLR_SEG, ANODO_EN, HORAS_EN, MODO};
            if (rst_act !== 11'b0000_1111_1_00) begin
                miscompares++;
                $display("FAIL reset_values cyc=%0d got %b expected 00001111100", cyc, rst_act);
            end
        end else begin
            exp_m = expected_disp(cyc);
            vectors++;
            if ({MODO, ANODO_EN, HORAS_EN} !== exp_m) begin
                miscompares++;
                $display("FAIL disp cyc=%0d got modo=%b anodo=%b horas=%b expected modo=%b anodo=%b horas=%b",
                         cyc, MODO, ANODO_EN, HORAS_EN, exp_m[6:5], exp_m[4:1], exp_m[0]);
            end
            check_pulse(CE_SEG, K_CE);
            check_pulse(INC_MIN, K_MIN);
            check_pulse(INC_HORA, K_HORA);
            check_pulse(CLR_SEG, K_CLR);
            for (int i = esperados.size() - 1; i >= 0; i--) begin
                if (esperados[i].c <= cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL %s cyc=%0d got 0 expected 1", kname(esperados[i].k), esperados[i].c);
                    esperados.delete(i);
                end
            end
        end
        if (fin) begin
            for (int i = 0; i < esperados.size(); i++) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_pending cyc=%0d got 0 expected 1", kname(esperados[i].k), esperados[i].c);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got no end expected finish", cyc);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_tick();
        int n;
        n = cyc;
        TICK_1HZ = 1'b1;
        if (mode_at(n) == 0) push(n + 1, K_CE);
        @(negedge CLK);
        TICK_1HZ = 1'b0;
    endtask

    task automatic model_modo(input int n);
        int from;
        from = mode_at(n + LAT - 1);
        if (from == 2) push(n + LAT, K_CLR);
        m_prev = m_cur;
        e_prev = e_cur;
        m_cur  = (from == 0) ? 1 : (from == 1) ? 2 : 0;
        m_cyc  = n + LAT;
        e_cur  = n + LAT;
    endtask

    task automatic model_inc(input int n, input int h);
        int m;
        int k;
        m = mode_at(n + LAT - 1);
        if (m == 1 || m == 2) begin
            k = (m == 1) ? K_HORA : K_MIN;
            push(n + LAT, k);
            for (int j = 0; RINI + j * RPER <= h; j++) push(n + LAT + RINI + j * RPER, k);
        end
    endtask

    // Raw press held for h sampled cycles; both buttons together model a collision.
    task automatic press(input bit modo, input bit inc, input int h);
        int n;
        n = cyc;
        if (modo) BTN_MODO = 1'b1;
        if (inc) BTN_INC = 1'b1;
        if (h >= DEB) begin
            if (modo) model_modo(n);
            else if (inc) model_inc(n, h);
        end
        idle(h);
        BTN_MODO = 1'b0;
        BTN_INC  = 1'b0;
        idle(DEB + 8);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            BTN_MODO = ($urandom_range(0, 1) == 1);
            BTN_INC  = ($urandom_range(0, 1) == 1);
            TICK_1HZ = ($urandom_range(0, 1) == 1);
        end
        @(negedge CLK);
        BTN_MODO = 1'b0;
        BTN_INC  = 1'b0;
        TICK_1HZ = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        idle(2);

        repeat (4) begin
            do_tick();
            idle(9);
        end

        press(1'b1, 1'b0, 3);

        n = cyc;
        BTN_MODO = 1'b1;
        model_modo(n);
        idle(6);
        do_tick();
        idle(3);
        BTN_MODO = 1'b0;
        idle(DEB + 8);
        repeat (2) begin
            do_tick();
            idle(5);
        end

        press(1'b0, 1'b1, 6);
        press(1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 7);

        press(1'b1, 1'b0, 5);
        press(1'b1, 1'b0, 5);
        press(1'b0, 1'b1, 54);
        idle(40);
        press(1'b1, 1'b1, 8);
        press(1'b1, 1'b0, 6);
        press(1'b1, 1'b1, 9);

        press(1'b1, 1'b0, 6);
        press(1'b1, 1'b0, 6);
        n = cyc;
        BTN_INC = 1'b1;
        push(n + LAT, K_HORA);
        idle(12);
        #2;
        RST = 1'b0;
        esperados.delete();
        m_prev = 0;
        m_cur  = 0;
        m_cyc  = 0;
        idle(4);
        RST = 1'b1;
        idle(20);
        BTN_INC = 1'b0;
        idle(12);
        press(1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 6);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    do_tick();
                    idle($urandom_range(1, 6));
                end
                1: press(1'b1, 1'b0, $urandom_range(DEB, 12));
                2: press(1'b0, 1'b1, $urandom_range(1, 40));
                3: press(1'b1, 1'b1, $urandom_range(DEB, 15));
                4: press(1'b1, 1'b0, $urandom_range(1, DEB - 1));
                default: idle($urandom_range(1, 20));
            endcase
        end

        idle(10);
        fin = 1'b1;
    end

endmodule
